// File: rtl/vector_list_if.sv
// Host write / drawer fetch bundle of the double-buffered vector store.
// The slave modport is the store's view; master is the host plus drawer side.
interface vector_list_if #(
    parameter int DEPTH_LOG2 = 9,
    parameter int CW         = 16
);
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [40+CW-1:0]      wr_data;
    logic [DEPTH_LOG2:0]   wr_count;
    logic                  commit;
    logic                  busy;
    logic                  vtrigger;
    logic                  read_vector;
    logic [9:0]            vector_nr;
    logic [9:0]            x0;
    logic [9:0]            y0;
    logic [9:0]            x1;
    logic [9:0]            y1;
    logic [CW-1:0]         col;
    logic                  last_vector;

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_count, commit, vtrigger,
        input  read_vector, vector_nr,
        output busy, x0, y0, x1, y1, col, last_vector
    );

    modport master (
        output wr_en, wr_addr, wr_data, wr_count, commit, vtrigger,
        output read_vector, vector_nr,
        input  busy, x0, y0, x1, y1, col, last_vector
    );
endinterface

// File: rtl/vector_list.sv
// Double-buffered vector list: the host fills the back bank and commits, the
// banks swap on the next vtrigger, and the drawer fetches with 1-cycle latency.
module vector_list #(
    parameter int DEPTH_LOG2 = 9,
    parameter int CW         = 16
) (
    input logic              clk,
    input logic              reset,
    vector_list_if.slave     bus
);
    localparam int ENTRY_W = 40 + CW;
    localparam int CNT_W   = DEPTH_LOG2 + 1;
    localparam int CMP_W   = (CNT_W > 10) ? CNT_W : 10;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << DEPTH_LOG2;

    // Handshake: commit is a one-cycle request; busy (the pending flag) stays
    // high until the swap and drops writes meanwhile. read_vector in cycle N
    // yields fields and last_vector in cycle N+1, held until the next fetch.
    logic [ENTRY_W-1:0] mem [0:2*(1<<DEPTH_LOG2)-1];

    logic               front;
    logic               pending;
    logic [CNT_W-1:0]   front_count;
    logic [CNT_W-1:0]   back_count;
    logic [ENTRY_W-1:0] rd_q;
    logic               last_q;

    logic               wr_accept;
    logic [CNT_W-1:0]   clamped_count;
    logic               beyond;
    logic               swap;

    always_comb begin
        wr_accept     = bus.wr_en && !pending;
        clamped_count = (bus.wr_count > DEPTH) ? DEPTH : bus.wr_count;
        beyond        = CMP_W'(bus.vector_nr) >= CMP_W'(front_count);
        // A commit landing in the vtrigger cycle swaps straight away.
        swap          = bus.vtrigger && (pending || bus.commit);
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{~front, bus.wr_addr}] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            front       <= 1'b0;
            pending     <= 1'b0;
            front_count <= '0;
            back_count  <= '0;
        end else begin
            if (bus.commit) begin
                back_count <= clamped_count;
            end
            if (swap) begin
                front       <= ~front;
                front_count <= bus.commit ? clamped_count : back_count;
                pending     <= 1'b0;
            end else if (bus.commit) begin
                pending     <= 1'b1;
            end
        end
    end

    // Out-of-range fetches leave the field register alone; those fields are
    // don't-care anyway and this keeps the RAM port quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q   <= '0;
            last_q <= 1'b1;
        end else if (bus.read_vector) begin
            last_q <= beyond;
            if (!beyond) begin
                rd_q <= mem[{front, bus.vector_nr[DEPTH_LOG2-1:0]}];
            end
        end
    end

    assign bus.busy        = pending;
    assign bus.x0          = rd_q[9:0];
    assign bus.y0          = rd_q[19:10];
    assign bus.x1          = rd_q[29:20];
    assign bus.y1          = rd_q[39:30];
    assign bus.col         = rd_q[40 +: CW];
    assign bus.last_vector = last_q;
endmodule

// File: tb/tb_vector_list.sv
// Randomized bench for vector_list with a bank-level reference model and an
// expected-fetch queue.
module tb_vector_list;
    localparam int DL   = 9;
    localparam int CW   = 16;
    localparam int EW   = 40 + CW;
    localparam int NENT = 1 << DL;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    vector_list_if #(.DEPTH_LOG2(DL), .CW(CW)) vif ();

    vector_list #(.DEPTH_LOG2(DL), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif.slave)
    );

    always #5 clk = ~clk;

    // Reference model: two physical banks plus the displayed/staged counts.
    logic [EW-1:0] m_bank [0:1][0:NENT-1];
    int            m_front;
    int            m_front_cnt;
    int            m_back_cnt;
    bit            m_pending;
    bit            m_last;
    logic [EW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_fields();
        return 64'({vif.col, vif.y1, vif.x1, vif.y0, vif.x0});
    endfunction

    task automatic idle();
        reset           = 1'b0;
        vif.wr_en       = 1'b0;
        vif.wr_addr     = '0;
        vif.wr_data     = '0;
        vif.wr_count    = '0;
        vif.commit      = 1'b0;
        vif.vtrigger    = 1'b0;
        vif.read_vector = 1'b0;
        vif.vector_nr   = '0;
    endtask

    // Advance one clock with whatever inputs are driven, then score outputs.
    task automatic step();
        bit fetch_in_range;
        bit was_reset;
        int clamp;
        fetch_in_range = 1'b0;
        was_reset      = reset;
        if (reset) begin
            m_front     = 0;
            m_front_cnt = 0;
            m_back_cnt  = 0;
            m_pending   = 1'b0;
            m_last      = 1'b1;
            exp_q.delete();
        end else begin
            if (vif.read_vector) begin
                m_last = (int'(vif.vector_nr) >= m_front_cnt);
                if (!m_last) begin
                    exp_q.push_back(m_bank[m_front][int'(vif.vector_nr) % NENT]);
                    fetch_in_range = 1'b1;
                end
            end
            if (vif.wr_en && !m_pending)
                m_bank[1 - m_front][vif.wr_addr] = vif.wr_data;
            clamp = (int'(vif.wr_count) > NENT) ? NENT : int'(vif.wr_count);
            if (vif.commit) m_back_cnt = clamp;
            if (vif.vtrigger && (m_pending || vif.commit)) begin
                m_front     = 1 - m_front;
                m_front_cnt = m_back_cnt;
                m_pending   = 1'b0;
            end else if (vif.commit) begin
                m_pending = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("busy", 64'(vif.busy), 64'(m_pending));
        check("last_vector", 64'(vif.last_vector), 64'(m_last));
        if (was_reset) check("reset_fields", dut_fields(), 64'd0);
        if (fetch_in_range) check("fields", dut_fields(), 64'(exp_q.pop_front()));
    endtask

    task automatic write_entry(input int addr, input logic [EW-1:0] data);
        idle();
        vif.wr_en   = 1'b1;
        vif.wr_addr = DL'(addr);
        vif.wr_data = data;
        step();
        idle();
    endtask

    task automatic commit_frame(input int cnt, input bit with_vtrigger);
        idle();
        vif.commit   = 1'b1;
        vif.wr_count = (DL+1)'(cnt);
        vif.vtrigger = with_vtrigger;
        step();
        idle();
    endtask

    task automatic vtrig();
        idle();
        vif.vtrigger = 1'b1;
        step();
        idle();
    endtask

    task automatic fetch(input int nr);
        idle();
        vif.read_vector = 1'b1;
        vif.vector_nr   = 10'(nr);
        step();
        idle();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        idle();
    endtask

    function automatic logic [EW-1:0] rand_entry();
        return {24'($urandom()), $urandom()};
    endfunction

    localparam logic [EW-1:0] E1 = {16'hF800, 10'd470, 10'd600, 10'd7, 10'd5};

    initial begin
        logic [EW-1:0] saved;
        idle();
        do_reset();

        // Fill both banks so every fetch reads defined data.
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < NENT; a++) write_entry(a, rand_entry());
            commit_frame(NENT, 1'b0);
            vtrig();
        end

        // Reset state: empty list, zeroed fields.
        do_reset();
        fetch(0);
        check("reset_last", 64'(vif.last_vector), 64'd1);
        check("reset_zero", dut_fields(), 64'd0);
        check("reset_busy", 64'(vif.busy), 64'd0);

        // Three-entry frame, committed and swapped.
        write_entry(0, rand_entry());
        write_entry(1, E1);
        write_entry(2, rand_entry());
        commit_frame(3, 1'b0);
        check("busy_after_commit", 64'(vif.busy), 64'd1);
        for (int i = 0; i < 3; i++) step();
        vtrig();
        fetch(1);
        check("e1_fields", dut_fields(), 64'(E1));
        check("e1_last", 64'(vif.last_vector), 64'd0);
        fetch(3);
        check("e3_last", 64'(vif.last_vector), 64'd1);
        check("busy_after_swap", 64'(vif.busy), 64'd0);

        // Uncommitted writes stay invisible across a vtrigger.
        for (int a = 0; a < 3; a++) write_entry(a, rand_entry());
        vtrig();
        for (int a = 0; a < 4; a++) fetch(a);

        // Writes while busy are dropped.
        write_entry(1, rand_entry());
        saved = m_bank[1 - m_front][1];
        commit_frame(3, 1'b0);
        write_entry(1, rand_entry());
        vtrig();
        fetch(1);
        check("dropped_write", dut_fields(), 64'(saved));

        // Commit and vtrigger together, oversize count clamps to the depth.
        commit_frame(600, 1'b1);
        check("same_cycle_busy", 64'(vif.busy), 64'd0);
        fetch(511);
        check("lv511", 64'(vif.last_vector), 64'd0);
        fetch(512);
        check("lv512", 64'(vif.last_vector), 64'd1);

        // Back-to-back fetches, then reset in the middle.
        for (int a = 0; a < 3; a++) begin
            vif.read_vector = 1'b1;
            vif.vector_nr   = 10'(a);
            step();
        end
        vif.vector_nr = 10'd3;
        reset         = 1'b1;
        step();
        idle();
        check("mid_reset_last", 64'(vif.last_vector), 64'd1);
        check("mid_reset_zero", dut_fields(), 64'd0);
        check("mid_reset_busy", 64'(vif.busy), 64'd0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            reset           = ($urandom_range(0, 399) == 0);
            vif.wr_en       = ($urandom_range(0, 1) == 1);
            vif.wr_addr     = DL'($urandom_range(0, NENT - 1));
            vif.wr_data     = rand_entry();
            vif.wr_count    = (DL+1)'($urandom_range(0, 1023));
            vif.commit      = ($urandom_range(0, 29) == 0);
            vif.vtrigger    = ($urandom_range(0, 39) == 0);
            vif.read_vector = ($urandom_range(0, 9) < 7);
            vif.vector_nr   = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 1023))
                                                          : 10'($urandom_range(0, 15));
            step();
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vector_list.md
# vector_list

Double-buffered vector store that feeds the line drawer with the endpoints and colour of each vector in a frame. A host writes a new frame into the back bank and commits it; the block swaps banks on the next `vtrigger`, so the drawer never sees a half-written list. It replaces the hard-coded vector generator in the top level and answers the drawer's `read_vector`/`vector_nr` fetches with registered fields and a `last_vector` flag.

## Interface
- `DEPTH_LOG2`, 9: log2 of the entries per bank (512).
- `CW`, 16: colour width, RGB565.

- `clk`  in  1  system clock (100 MHz domain); every register is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  host write strobe for the back bank.
- `wr_addr`  in  DEPTH_LOG2  entry index in the back bank.
- `wr_data`  in  40+CW  packed entry: {col[CW-1:0], y1[9:0], x1[9:0], y0[9:0], x0[9:0]}, with x0 in the LSBs.
- `wr_count`  in  DEPTH_LOG2+1  number of valid entries in the back bank; sampled on `commit`.
- `commit`  in  1  single-cycle pulse: back bank is complete, swap at the next `vtrigger`.
- `busy`  out  1  high while a commit is pending. Writes are ignored while high.
- `vtrigger`  in  1  frame trigger from the vga block, single-cycle pulse.
- `read_vector`  in  1  fetch request from the line drawer.
- `vector_nr`  in  10  index being fetched.
- `x0`, `y0`, `x1`, `y1`  out  10 each  registered endpoints.
- `col`  out  CW  registered colour.
- `last_vector`  out  1  registered: `vector_nr` was at or beyond the displayed count.

## Operation
- Storage: two banks of 2^DEPTH_LOG2 × (40+CW), each with a synchronous read port. `front` selects the displayed bank; the host writes bank `~front`.
- Write path: when `wr_en` is high and `busy` is low, the entry at `{~front, wr_addr}` is written. When `wr_en` is high and `busy` is high, the write is dropped with no side effect.
- Commit: on `commit`, `pending` is set to 1 and `back_count` is set to `min(wr_count, 2^DEPTH_LOG2)`. A `commit` while `pending` is already 1 re-latches `back_count` and leaves `pending` at 1.
- Swap: on `vtrigger` with `pending` = 1:
  - `front` toggles.
  - `front_count` is set to `back_count`.
  - `pending` clears.
  - A `vtrigger` with `pending` = 0 changes nothing; the same frame is redrawn.
- Commit and `vtrigger` in the same cycle: the swap happens in that cycle, using the `wr_count` value from that cycle.
- `busy` is the `pending` register.
- Read path, on `read_vector`:
  - RAM address is `{front, vector_nr[DEPTH_LOG2-1:0]}`.
  - `last_vector` is set to (`vector_nr` >= `front_count`), compared at full 10-bit width zero-extended.
  - The fields are taken from the RAM output register.
  - When `last_vector` = 1, the field values are don't-care.
- Hold: with `read_vector` low, all outputs hold their last values.
- Empty frame: if `front_count` = 0, every fetch returns `last_vector` = 1.
- Reset values:
  - `front` = 0, `front_count` = 0, `back_count` = 0, `pending` = 0, `busy` = 0.
  - `x0`, `y0`, `x1`, `y1` = 0, `col` = 0, `last_vector` = 1.
  - RAM contents are not cleared.
- Reset mid-frame: the displayed list reverts to empty, and any pending commit is lost.

## Timing
- Fetch latency is 1 cycle. With `read_vector` high in cycle N, all outputs are valid from cycle N+1 and stay valid until the next fetch. This matches the drawer's one-cycle registered-fetch expectation.
- Back-to-back fetches on consecutive cycles are supported: one result per cycle.
- Bank swap timing:
  - The swap is registered on the `vtrigger` edge and takes effect from cycle N+1.
  - A fetch in the `vtrigger` cycle itself still reads the old bank and the old `front_count`.
- Write-to-display latency: a committed write becomes visible at the first fetch after the next `vtrigger`.
- Write versus read of the same physical bank cannot collide: the host always writes bank `~front`, and `front` cannot change while writes are accepted, because `busy` gates them.

## Test plan
- After reset, fetch `vector_nr`=0 -> next cycle `last_vector`=1, `x0`=`y0`=`x1`=`y1`=0, `col`=0; `busy`=0.
- Write 3 entries (entry 1 = x0 5, y0 7, x1 600, y1 470, col 16'hF800), `commit` with `wr_count`=3 -> `busy`=1 until `vtrigger`. Next cycle after `vtrigger`: fetch 1 returns exactly those fields with `last_vector`=0; fetch 3 returns `last_vector`=1; `busy`=0.
- With a frame displayed, write new data to the back bank without committing, then pulse `vtrigger` -> fetches still return the old frame.
- `commit` while `busy` is high, followed by `wr_en` to address 1 with new data -> the write is dropped; after the swap, entry 1 still holds its pre-commit contents.
- `commit` and `vtrigger` in the same cycle with `wr_count`=600 and `DEPTH_LOG2`=9 -> swap occurs; fetch 511 gives `last_vector`=0, fetch 512 gives `last_vector`=1.
- Back-to-back fetches 0,1,2 in cycles N..N+2 -> outputs match entries 0,1,2 in cycles N+1..N+3. Assert `reset` mid-sequence -> next cycle outputs are 0, `last_vector`=1, `busy`=0.
